// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   size_e     : access size encoding (byte, half, word, double)
//   state_e    : lsu_dmem controller states
//   size_bytes : number of bytes for a given size
//   byte_mask  : 16-bit byte-enable pattern for a size at a byte offset;
//                bits [15:8] only become non-zero for line-crossing accesses
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // ST_REQ/ST_WAIT double as the first beat of a split access.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_REQ1  = 3'd4,
    ST_WAIT1 = 3'd5
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e size);
    return 4'd1 << size;
  endfunction

  function automatic logic [15:0] byte_mask(input size_e size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << size_bytes(size)) - 16'd1;
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane alignment shared by every memory beat.
//   size, is_unsigned, off : captured access attributes
//   st_data  -> st_lanes   : store data shifted to its byte lanes (128 bits
//                            so a line-crossing store spills into [127:64])
//   st_mask                : matching 16-bit byte enables
//   ld_lo, ld_hi -> ld_data: two consecutive memory words shifted down by
//                            the offset, truncated and sign/zero extended
module lsu_align
  import lsu_pkg::*;
(
  input  size_e        size,
  input  logic         is_unsigned,
  input  logic [2:0]   off,
  input  logic [63:0]  st_data,
  output logic [127:0] st_lanes,
  output logic [15:0]  st_mask,
  input  logic [63:0]  ld_lo,
  input  logic [63:0]  ld_hi,
  output logic [63:0]  ld_data
);

  logic [5:0]   sh_bits;
  logic [127:0] ld_shift;
  logic         unused_ld_top;

  assign sh_bits  = {off, 3'b000};
  assign st_lanes = {64'd0, st_data} << sh_bits;
  assign st_mask  = byte_mask(size, off);
  assign ld_shift = {ld_hi, ld_lo} >> sh_bits;

  assign unused_ld_top = ^ld_shift[127:64];

  always_comb begin
    ld_data = ld_shift[63:0];
    case (size)
      SZ_B: ld_data = is_unsigned ? {56'd0, ld_shift[7:0]}
                                  : {{56{ld_shift[7]}}, ld_shift[7:0]};
      SZ_H: ld_data = is_unsigned ? {48'd0, ld_shift[15:0]}
                                  : {{48{ld_shift[15]}}, ld_shift[15:0]};
      SZ_W: ld_data = is_unsigned ? {32'd0, ld_shift[31:0]}
                                  : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift[63:0];  // doubleword: no extension
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit between the core execute stage and a 64-bit
// data memory with a req/gnt + rvalid handshake. One access in flight.
//   core side : req_valid/req_ready, req_we, req_size, req_unsigned,
//               req_addr, req_wdata -> resp_valid, resp_rdata, resp_err
//   memory    : mem_req/mem_gnt, mem_we, mem_addr (8-byte aligned),
//               mem_wdata, mem_wmask, mem_rvalid, mem_rdata
//   clk, rst  : rst is synchronous, active-high
// Build option LSU_MISALIGN_SPLIT_EN: line-crossing accesses are split into
// two beats instead of returning resp_err.
//
// state    | meaning
// ST_IDLE  | ready for a new request
// ST_REQ   | mem_req asserted for the (first) beat, waiting for mem_gnt
// ST_WAIT  | granted, waiting for mem_rvalid of the (first) beat
// ST_REQ1  | split only: second beat request to base + 8
// ST_WAIT1 | split only: waiting for mem_rvalid of the second beat
// ST_RESP  | one-cycle resp_valid pulse
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [60:0] addr_q, addr_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic         misaligned;
  logic         in_req;
  logic         beat1;
  logic [127:0] st_lanes;
  logic [15:0]  st_mask;
  logic [63:0]  ld_lo, ld_hi, ld_data;
  logic [63:0]  mem_addr_full;

  // Crossing the 8-byte line: offset plus access length exceeds 8.
  assign misaligned = ({1'b0, req_addr[2:0]} + size_bytes(size_e'(req_size))) > 4'd8;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q, split_d;
  logic [63:0] rdata0_q, rdata0_d;

  assign in_req = (state_q == ST_REQ) || (state_q == ST_REQ1);
  assign beat1  = (state_q == ST_REQ1);
  // Second beat merges the held first word under the live second word.
  assign ld_lo  = (state_q == ST_WAIT1) ? rdata0_q  : mem_rdata;
  assign ld_hi  = (state_q == ST_WAIT1) ? mem_rdata : 64'd0;
`else
  logic unused_hi_lanes;

  assign in_req = (state_q == ST_REQ);
  assign beat1  = 1'b0;
  assign ld_lo  = mem_rdata;
  assign ld_hi  = 64'd0;
  assign unused_hi_lanes = ^{st_lanes[127:64], st_mask[15:8]};
`endif

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (off_q),
    .st_data     (wdata_q),
    .st_lanes    (st_lanes),
    .st_mask     (st_mask),
    .ld_lo       (ld_lo),
    .ld_hi       (ld_hi),
    .ld_data     (ld_data)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_valid & resp_err_q;

  // mem_req is gated by rst so the request drops in the reset cycle itself.
  assign mem_req       = in_req & ~rst;
  assign mem_we        = in_req & we_q;
  assign mem_addr_full = in_req ? {addr_q + {60'd0, beat1}, 3'b000} : 64'd0;
  assign mem_addr      = mem_addr_full[MEM_AW-1:0];
  assign mem_wdata     = !in_req ? 64'd0 : (beat1 ? st_lanes[127:64] : st_lanes[63:0]);
  assign mem_wmask     = !in_req ? 8'd0  : (beat1 ? st_mask[15:8]    : st_mask[7:0]);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d      = split_q;
    rdata0_d     = rdata0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          size_d       = size_e'(req_size);
          uns_d        = req_unsigned;
          addr_d       = req_addr[63:3];
          off_d        = req_addr[2:0];
          wdata_d      = req_wdata;
          resp_rdata_d = 64'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d      = misaligned;
          resp_err_d   = 1'b0;
          state_d      = ST_REQ;
`else
          resp_err_d   = misaligned;
          state_d      = misaligned ? ST_RESP : ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            rdata0_d = mem_rdata;
            state_d  = ST_REQ1;
          end else begin
            resp_rdata_d = we_q ? 64'd0 : ld_data;
            state_d      = ST_RESP;
          end
`else
          resp_rdata_d = we_q ? 64'd0 : ld_data;
          state_d      = ST_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_REQ1: begin
        if (mem_gnt) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          resp_rdata_d = we_q ? 64'd0 : ld_data;
          state_d      = ST_RESP;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      addr_q       <= 61'd0;
      off_q        <= 3'd0;
      wdata_q      <= 64'd0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q      <= 1'b0;
      rdata0_q     <= 64'd0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q      <= split_d;
      rdata0_q     <= rdata0_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed self-checking bench for lsu_dmem. Expected memory
// beats and responses are queued when a request is driven and checked when
// the DUT presents them.
module tb_lsu_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  always #5 clk = ~clk;

  lsu_dmem #(.MEM_AW(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic        we;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic [63:0] addr, input logic [7:0] mask,
                          input logic [63:0] wdata, input logic we, input logic [63:0] rdata);
    beat_t b;
    b.addr = addr; b.mask = mask; b.wdata = wdata; b.we = we; b.rdata = rdata;
    beat_q.push_back(b);
  endtask

  task automatic exp_resp(input logic [63:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata; r.err = err;
    resp_q.push_back(r);
  endtask

  task automatic check_beat(input string tag, input beat_t b);
    chk({tag, "_mem_req"},   64'(mem_req),   64'd1);
    chk({tag, "_mem_addr"},  mem_addr,       b.addr);
    chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'(b.mask));
    chk({tag, "_mem_wdata"}, mem_wdata,      b.wdata);
    chk({tag, "_mem_we"},    64'(mem_we),    64'(b.we));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Drives one request, plays memory for each expected beat, then checks the
  // response against the scoreboard and the accept-to-resp_valid latency.
  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input int gnt_wait, input int exp_lat);
    int    lat;
    int    beats_seen;
    int    beats_exp;
    beat_t b;
    resp_t r;
    beats_exp = beat_q.size();
    chk({tag, "_ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    lat = 1;
    beats_seen = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (mem_req === 1'b1) begin
        beats_seen++;
        if (beat_q.size() > 0) b = beat_q.pop_front();
        else begin
          b.addr = 64'd0; b.mask = 8'd0; b.wdata = 64'd0; b.we = 1'b0; b.rdata = 64'd0;
        end
        for (int i = 0; i < gnt_wait; i++) begin
          check_beat($sformatf("%s_stall%0d", tag, i), b);
          tick();
          lat++;
        end
        check_beat($sformatf("%s_beat%0d", tag, beats_seen), b);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        lat++;
        chk({tag, "_req_drop"}, 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = b.rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        lat++;
      end else begin
        tick();
        lat++;
      end
    end
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_latency"},    64'(lat),        64'(exp_lat));
    chk({tag, "_beats"},      64'(beats_seen), 64'(beats_exp));
    if (resp_q.size() > 0) begin
      r = resp_q.pop_front();
      chk({tag, "_rdata"}, resp_rdata,     r.rdata);
      chk({tag, "_err"},   64'(resp_err),  64'(r.err));
    end else begin
      chk({tag, "_scoreboard"}, 64'(resp_q.size()), 64'd1);
    end
    tick();
    chk({tag, "_pulse_end"}, 64'(resp_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err",   64'(resp_err),   64'd0);
    chk("rst_resp_rdata", resp_rdata,      64'd0);
    chk("rst_mem_req",    64'(mem_req),    64'd0);
    chk("rst_mem_we",     64'(mem_we),     64'd0);
    chk("rst_mem_addr",   mem_addr,        64'd0);
    chk("rst_mem_wdata",  mem_wdata,       64'd0);
    chk("rst_mem_wmask",  64'(mem_wmask),  64'd0);
    rst = 1'b0;
    tick();

    // Stores
    exp_beat(64'h80001000, 8'hFF, 64'h1234567887654321, 1'b1, 64'hDEADBEEFDEADBEEF);
    exp_resp(64'd0, 1'b0);
    access("sd", 1'b1, 2'd3, 1'b0, 64'h80001000, 64'h1234567887654321, 0, 3);

    exp_beat(64'h80001000, 8'h20, 64'h0000AB0000000000, 1'b1, 64'd0);
    exp_resp(64'd0, 1'b0);
    access("sb", 1'b1, 2'd0, 1'b0, 64'h80001005, 64'h00000000000000AB, 0, 3);

    exp_beat(64'h80001000, 8'hC0, 64'hBEEF000000000000, 1'b1, 64'd0);
    exp_resp(64'd0, 1'b0);
    access("sh", 1'b1, 2'd1, 1'b0, 64'h80001006, 64'h000000000000BEEF, 0, 3);

    // Loads from the word 0x8765432112345678
    exp_beat(64'h80001000, 8'h08, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'h0000000000000012, 1'b0);
    access("lb", 1'b0, 2'd0, 1'b0, 64'h80001003, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'hC0, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'hFFFFFFFFFFFF8765, 1'b0);
    access("lh", 1'b0, 2'd1, 1'b0, 64'h80001006, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'hF0, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'h0000000087654321, 1'b0);
    access("lwu", 1'b0, 2'd2, 1'b1, 64'h80001004, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'hF0, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'hFFFFFFFF87654321, 1'b0);
    access("lw", 1'b0, 2'd2, 1'b0, 64'h80001004, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'h80, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'h0000000000000087, 1'b0);
    access("lbu7", 1'b0, 2'd0, 1'b1, 64'h80001007, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'h80, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'hFFFFFFFFFFFFFF87, 1'b0);
    access("lb7", 1'b0, 2'd0, 1'b0, 64'h80001007, 64'd0, 0, 3);

    exp_beat(64'h80001000, 8'hFF, 64'd0, 1'b0, 64'h8765432112345678);
    exp_resp(64'h8765432112345678, 1'b0);
    access("ld_uns", 1'b0, 2'd3, 1'b1, 64'h80001000, 64'd0, 0, 3);

    // Grant stalled for four cycles
    exp_beat(64'h80002000, 8'hF0, 64'hCAFEF00D00000000, 1'b1, 64'd0);
    exp_resp(64'd0, 1'b0);
    access("sw_stall", 1'b1, 2'd2, 1'b0, 64'h80002004, 64'h00000000CAFEF00D, 4, 7);

    // Line-crossing accesses
`ifdef LSU_MISALIGN_SPLIT_EN
    exp_beat(64'h80001000, 8'hC0, 64'd0, 1'b0, 64'h8765432112345678);
    exp_beat(64'h80001008, 8'h03, 64'd0, 1'b0, 64'h111122223333C0DE);
    exp_resp(64'hFFFFFFFFC0DE8765, 1'b0);
    access("lw_split", 1'b0, 2'd2, 1'b0, 64'h80001006, 64'd0, 0, 5);

    exp_beat(64'h80001000, 8'hC0, 64'hCCDD000000000000, 1'b1, 64'd0);
    exp_beat(64'h80001008, 8'h03, 64'h000000000000AABB, 1'b1, 64'd0);
    exp_resp(64'd0, 1'b0);
    access("sw_split", 1'b1, 2'd2, 1'b0, 64'h80001006, 64'h00000000AABBCCDD, 0, 5);
`else
    exp_resp(64'd0, 1'b1);
    access("lw_misalign", 1'b0, 2'd2, 1'b0, 64'h80001006, 64'd0, 0, 1);

    exp_resp(64'd0, 1'b1);
    access("sd_misalign", 1'b1, 2'd3, 1'b0, 64'h80001001, 64'h0123456789ABCDEF, 0, 1);
`endif

    // Reset while requesting: mem_req drops in the reset cycle
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h80003000; req_wdata = 64'd0;
    tick();
    req_valid = 1'b0;
    chk("rstreq_mem_req_on", 64'(mem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstreq_mem_req_drop", 64'(mem_req), 64'd0);
    tick();
    rst = 1'b0;
    chk("rstreq_ready", 64'(req_ready), 64'd1);

    // Reset while waiting for rvalid; the late rvalid must be ignored
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstwait_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0123456789ABCDEF;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstwait_no_resp%0d", i), 64'(resp_valid), 64'd0);
      tick();
    end
    chk("rstwait_ready",   64'(req_ready), 64'd1);
    chk("rstwait_mem_req", 64'(mem_req),   64'd0);

    // Normal operation resumes after the reset
    exp_beat(64'h80004000, 8'h0C, 64'd0, 1'b0, 64'h00000000F00D0000);
    exp_resp(64'hFFFFFFFFFFFFF00D, 1'b0);
    access("lh_after_rst", 1'b0, 2'd1, 1'b0, 64'h80004002, 64'd0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
